// File: rtl/uart_rx_cfg.sv
// Purpose: configurable UART receiver (data/stop bits, optional parity via UART_RX_PARITY_EN, break detect).
// Latency: o_Rx_DV is raised the cycle after the last stop-bit sample; the input synchroniser adds 2 cycles.
// Backpressure: none; results are one-cycle strobes, and o_Rx_Byte/flags hold until the next frame completes.
module uart_rx_cfg #(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 i_Clock,
    input  logic                 i_Rst_n,
    input  logic                 i_Rx_Serial,
    output logic                 o_Rx_DV,
    output logic [DATA_BITS-1:0] o_Rx_Byte,
    output logic                 o_Frame_Err,
    output logic                 o_Parity_Err,
    output logic                 o_Break,
    output logic                 o_Busy
);

    // Counter spans 0..CLKS_PER_BIT-1 so it never wraps inside a bit period.
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);

    // One index serves both the data bits and the stop bits.
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    // Encodings are fixed so an unused code (7, or 3 without parity) is
    // caught by the default branch and returns to IDLE.
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY    = 3'd3,
`endif
        S_STOP      = 3'd4,
        S_CLEANUP   = 3'd5,
        S_WAIT_IDLE = 3'd6
    } state_t;

    state_t               state_q;
    state_t               state_nxt;
    logic [1:0]           sync_q;
    logic                 rx_s;
    logic [CNT_W-1:0]     cnt_q;
    logic [IDX_W-1:0]     idx_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 stop_err_q;
    logic                 all_zero_q;
    logic                 bit_tick;
    logic                 idx_data_last;
    logic                 idx_stop_last;
`ifdef UART_RX_PARITY_EN
    logic                 par_bit_q;
`endif

    assign rx_s          = sync_q[1];
    assign bit_tick      = (cnt_q == CNT_LAST);
    assign idx_data_last = (idx_q == IDX_LAST);
    assign idx_stop_last = (idx_q == STOP_LAST);
    assign o_Busy        = (state_q != S_IDLE);

    // Two-flop synchroniser for the asynchronous line; resets to idle-high.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], i_Rx_Serial};
        end
    end

    // FSM state register.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_nxt = S_START;
                end
            end
            S_START: begin
                // Mid-start-bit check: a high sample means the edge was a glitch.
                if (cnt_q == CNT_HALF) begin
                    state_nxt = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (bit_tick && idx_data_last) begin
`ifdef UART_RX_PARITY_EN
                    state_nxt = S_PARITY;
`else
                    state_nxt = S_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (bit_tick) begin
                    state_nxt = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (bit_tick && idx_stop_last) begin
                    state_nxt = S_CLEANUP;
                end
            end
            S_CLEANUP: begin
                // After a framing error the line may still be low (break);
                // wait for it to return high so it is reported only once.
                state_nxt = o_Frame_Err ? S_WAIT_IDLE : S_IDLE;
            end
            S_WAIT_IDLE: begin
                if (rx_s) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Bit timing, sampling and result registers.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            data_q       <= '0;
            stop_err_q   <= 1'b0;
            all_zero_q   <= 1'b0;
            o_Rx_DV      <= 1'b0;
            o_Rx_Byte    <= '0;
            o_Frame_Err  <= 1'b0;
            o_Break      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_q    <= 1'b0;
            o_Parity_Err <= 1'b0;
`endif
        end else begin
            o_Rx_DV <= 1'b0;
            o_Break <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    cnt_q      <= '0;
                    idx_q      <= '0;
                    stop_err_q <= 1'b0;
                    all_zero_q <= 1'b1;
                end
                S_START: begin
                    if (cnt_q == CNT_HALF) begin
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_tick) begin
                        cnt_q         <= '0;
                        data_q[idx_q] <= rx_s;
                        all_zero_q    <= all_zero_q & ~rx_s;
                        idx_q         <= idx_data_last ? '0 : idx_q + 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (bit_tick) begin
                        cnt_q      <= '0;
                        par_bit_q  <= rx_s;
                        all_zero_q <= all_zero_q & ~rx_s;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (bit_tick) begin
                        cnt_q <= '0;
                        if (idx_stop_last) begin
                            // Final stop sample: publish the whole frame at once.
                            idx_q       <= '0;
                            o_Rx_DV     <= 1'b1;
                            o_Rx_Byte   <= data_q;
                            o_Frame_Err <= stop_err_q | ~rx_s;
                            o_Break     <= all_zero_q & ~rx_s;
`ifdef UART_RX_PARITY_EN
                            o_Parity_Err <= (^data_q) ^ par_bit_q ^ PARITY_ODD[0];
`endif
                        end else begin
                            idx_q      <= idx_q + 1'b1;
                            stop_err_q <= stop_err_q | ~rx_s;
                            all_zero_q <= all_zero_q & ~rx_s;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    cnt_q <= '0;
                    idx_q <= '0;
                end
            endcase
        end
    end

`ifndef UART_RX_PARITY_EN
    // No parity bit on the line in this build; the sense parameter has no effect.
    assign o_Parity_Err = 1'b0 & PARITY_ODD[0];
`endif

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Purpose: directed self-checking bench for uart_rx_cfg (1-stop and 2-stop instances, CLKS_PER_BIT=16).
// Latency: each frame is driven bit by bit; results are checked a few cycles after the frame ends.
// Backpressure: not applicable; strobes are counted by a negedge monitor.
module tb_uart_rx_cfg;

    localparam int CPB = 16;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx1   = 1'b1;
    logic       rx2   = 1'b1;

    logic       dv1, fe1, pe1, brk1, busy1;
    logic [7:0] byte1;
    logic       dv2, fe2, pe2, brk2, busy2;
    logic [7:0] byte2;

    int vectors     = 0;
    int miscompares = 0;
    int dv1_cnt     = 0;
    int brk1_cnt    = 0;
    int dv2_cnt     = 0;
    int dv_base;
    int brk_base;

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) u_dut1 (
        .i_Clock      (clk),
        .i_Rst_n      (rst_n),
        .i_Rx_Serial  (rx1),
        .o_Rx_DV      (dv1),
        .o_Rx_Byte    (byte1),
        .o_Frame_Err  (fe1),
        .o_Parity_Err (pe1),
        .o_Break      (brk1),
        .o_Busy       (busy1)
    );

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(2), .PARITY_ODD(0)) u_dut2 (
        .i_Clock      (clk),
        .i_Rst_n      (rst_n),
        .i_Rx_Serial  (rx2),
        .o_Rx_DV      (dv2),
        .o_Rx_Byte    (byte2),
        .o_Frame_Err  (fe2),
        .o_Parity_Err (pe2),
        .o_Break      (brk2),
        .o_Busy       (busy2)
    );

    always #5 clk = ~clk;

    // Count strobes away from the active edge.
    always @(negedge clk) begin
        if (dv1)  dv1_cnt  = dv1_cnt + 1;
        if (brk1) brk1_cnt = brk1_cnt + 1;
        if (dv2)  dv2_cnt  = dv2_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors = vectors + 1;
        assert (obs === exp) else begin
            miscompares = miscompares + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_line(input int sel, input logic v);
        if (sel == 1) rx1 = v;
        else          rx2 = v;
    endtask

    task automatic send_bit(input int sel, input logic b);
        set_line(sel, b);
        repeat (CPB) @(negedge clk);
    endtask

    // Start bit, 8 data bits LSB first, optional parity (even sense, optionally flipped), nstop stop bits.
    task automatic send_frame(input int sel, input logic [7:0] d, input logic [1:0] stops,
                              input int nstop, input logic par_flip);
        logic par;
        par = (^d) ^ par_flip;
        send_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(sel, d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(sel, par);
`endif
        for (int i = 0; i < nstop; i++) send_bit(sel, stops[i]);
    endtask

    logic [7:0] patt [4];

    initial begin
        patt[0] = 8'hA5; patt[1] = 8'hFF; patt[2] = 8'h01; patt[3] = 8'h80;

        // Reset state.
        @(negedge clk);
        chk("rst_dv",   32'(dv1),   32'h0);
        chk("rst_byte", 32'(byte1), 32'h0);
        chk("rst_fe",   32'(fe1),   32'h0);
        chk("rst_pe",   32'(pe1),   32'h0);
        chk("rst_brk",  32'(brk1),  32'h0);
        chk("rst_busy", 32'(busy1), 32'h0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("idle_busy", 32'(busy1), 32'h0);

        // Clean frames, one stop bit.
        for (int k = 0; k < 4; k++) begin
            dv_base = dv1_cnt;
            send_frame(1, patt[k], 2'b11, 1, 1'b0);
            repeat (6) @(negedge clk);
            chk("clean_dv",   32'(dv1_cnt - dv_base), 32'd1);
            chk("clean_byte", 32'(byte1), 32'(patt[k]));
            chk("clean_fe",   32'(fe1),   32'h0);
            chk("clean_pe",   32'(pe1),   32'h0);
            chk("clean_busy", 32'(busy1), 32'h0);
        end

`ifdef UART_RX_PARITY_EN
        // Wrong then correct even parity on 0x03.
        send_frame(1, 8'h03, 2'b11, 1, 1'b1);
        repeat (6) @(negedge clk);
        chk("par_bad_byte", 32'(byte1), 32'h03);
        chk("par_bad_pe",   32'(pe1),   32'h1);
        send_frame(1, 8'h03, 2'b11, 1, 1'b0);
        repeat (6) @(negedge clk);
        chk("par_ok_pe",    32'(pe1),   32'h0);
`endif

        // Stop bit low: framing error, then stuck in WAIT_IDLE while line stays low.
        dv_base  = dv1_cnt;
        brk_base = brk1_cnt;
        send_frame(1, 8'h55, 2'b00, 1, 1'b0);
        repeat (40) @(negedge clk);
        chk("ferr_dv",   32'(dv1_cnt - dv_base),   32'd1);
        chk("ferr_byte", 32'(byte1), 32'h55);
        chk("ferr_fe",   32'(fe1),   32'h1);
        chk("ferr_brk",  32'(brk1_cnt - brk_base), 32'd0);
        chk("ferr_wait", 32'(busy1), 32'h1);
        set_line(1, 1'b1);
        repeat (10) @(negedge clk);
        chk("ferr_idle", 32'(busy1), 32'h0);

        // Line held low for 40 bit times: exactly one break report.
        dv_base  = dv1_cnt;
        brk_base = brk1_cnt;
        set_line(1, 1'b0);
        repeat (40 * CPB) @(negedge clk);
        chk("brk_dv",   32'(dv1_cnt - dv_base),   32'd1);
        chk("brk_brk",  32'(brk1_cnt - brk_base), 32'd1);
        chk("brk_byte", 32'(byte1), 32'h00);
        chk("brk_fe",   32'(fe1),   32'h1);
        chk("brk_busy", 32'(busy1), 32'h1);
        set_line(1, 1'b1);
        repeat (3 * CPB) @(negedge clk);
        chk("brk_rel_busy", 32'(busy1), 32'h0);
        chk("brk_rel_dv",   32'(dv1_cnt - dv_base), 32'd1);
        send_frame(1, 8'h42, 2'b11, 1, 1'b0);
        repeat (6) @(negedge clk);
        chk("post_brk_dv",   32'(dv1_cnt - dv_base),   32'd2);
        chk("post_brk_byte", 32'(byte1), 32'h42);
        chk("post_brk_fe",   32'(fe1),   32'h0);
        chk("post_brk_brk",  32'(brk1_cnt - brk_base), 32'd1);

        // 5-clock low glitch on idle line is rejected.
        dv_base = dv1_cnt;
        set_line(1, 1'b0);
        repeat (5) @(negedge clk);
        set_line(1, 1'b1);
        repeat (3 * CPB) @(negedge clk);
        chk("glitch_dv",   32'(dv1_cnt - dv_base), 32'd0);
        chk("glitch_byte", 32'(byte1), 32'h42);
        chk("glitch_fe",   32'(fe1),   32'h0);
        chk("glitch_busy", 32'(busy1), 32'h0);

        // Two stop bits: clean frame, then second stop bit low.
        dv_base = dv2_cnt;
        send_frame(2, 8'hC3, 2'b11, 2, 1'b0);
        repeat (6) @(negedge clk);
        chk("stop2_dv",   32'(dv2_cnt - dv_base), 32'd1);
        chk("stop2_byte", 32'(byte2), 32'hC3);
        chk("stop2_fe",   32'(fe2),   32'h0);
        send_frame(2, 8'h3C, 2'b01, 2, 1'b0);
        repeat (2 * CPB) @(negedge clk);
        chk("stop2_err_dv",   32'(dv2_cnt - dv_base), 32'd2);
        chk("stop2_err_byte", 32'(byte2), 32'h3C);
        chk("stop2_err_fe",   32'(fe2),   32'h1);
        chk("stop2_err_wait", 32'(busy2), 32'h1);
        set_line(2, 1'b1);
        repeat (10) @(negedge clk);
        chk("stop2_err_idle", 32'(busy2), 32'h0);
        chk("stop2_err_once", 32'(dv2_cnt - dv_base), 32'd2);

        // Reset during bit 4 of 0x5A, then a clean 0x81.
        dv_base = dv1_cnt;
        send_bit(1, 1'b0);
        send_bit(1, 1'b0);
        send_bit(1, 1'b1);
        send_bit(1, 1'b0);
        send_bit(1, 1'b1);
        set_line(1, 1'b1);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 32'(busy1), 32'h0);
        chk("midrst_byte", 32'(byte1), 32'h00);
        chk("midrst_fe",   32'(fe1),   32'h0);
        rst_n = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        chk("midrst_nodv", 32'(dv1_cnt - dv_base), 32'd0);
        send_frame(1, 8'h81, 2'b11, 1, 1'b0);
        repeat (6) @(negedge clk);
        chk("after_rst_dv",   32'(dv1_cnt - dv_base), 32'd1);
        chk("after_rst_byte", 32'(byte1), 32'h81);
        chk("after_rst_fe",   32'(fe1),   32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
